hazard_forward_unit: RTL and testbench



---
 rtl/hazard_forward_unit_if.sv | 31 +++
 rtl/hazard_forward_unit.sv | 102 ++++++++++
 tb/tb_hazard_forward_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID-stage instruction fields in, forwarding and stall controls out
interface hazard_forward_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             fwd_id_a;
    logic             fwd_id_b;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread, flush,
        input  fwd_a, fwd_b, fwd_id_a, fwd_id_b, stall, bubble, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_regwrite, id_memread, flush,
        output fwd_a, fwd_b, fwd_id_a, fwd_id_b, stall, bubble, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: shadow-pipeline forwarding selects, WB-to-ID bypass and multi-cycle load-use stalls
module hazard_forward_unit #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic                  clk,
    input logic                  reset,
    hazard_forward_unit_if.slave hf
);
    typedef enum logic {IDLE, STALL} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [REG_W-1:0] idex_rs_q, idex_rt_q, idex_rd_q, exmem_rd_q, memwb_rd_q;
    logic             idex_rw_q, idex_mr_q, exmem_rw_q, memwb_rw_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic             exmem_live, memwb_live, detect, stall, bubble;

    assign exmem_live = exmem_rw_q && exmem_rd_q != '0;
    assign memwb_live = memwb_rw_q && memwb_rd_q != '0;

    assign hf.fwd_a = (exmem_live && exmem_rd_q == idex_rs_q) ? 2'b10 :
                      (memwb_live && memwb_rd_q == idex_rs_q) ? 2'b01 : 2'b00;
    assign hf.fwd_b = (exmem_live && exmem_rd_q == idex_rt_q) ? 2'b10 :
                      (memwb_live && memwb_rd_q == idex_rt_q) ? 2'b01 : 2'b00;

    assign hf.fwd_id_a = hf.id_valid && memwb_live && memwb_rd_q == hf.id_rs;
    assign hf.fwd_id_b = hf.id_valid && hf.id_uses_rt && memwb_live && memwb_rd_q == hf.id_rt;

    assign detect = hf.id_valid && !hf.flush && idex_mr_q && idex_rw_q && idex_rd_q != '0 &&
                    (idex_rd_q == hf.id_rs || (hf.id_uses_rt && idex_rd_q == hf.id_rt));

    assign bubble          = stall || hf.flush;
    assign hf.stall        = stall;
    assign hf.bubble       = bubble;
    assign hf.stall_cycles = stall_cycles_q;

    // Stall sequencing: the detect cycle is the first bubble, STALL covers the remaining LOAD_LAT-1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = detect;
        if (state_q == IDLE) begin
            if (detect && LOAD_LAT > 1) begin
                state_d = STALL;
                cnt_d   = 2'(LOAD_LAT - 1);
            end
        end else begin
            stall = !hf.flush;
            if (hf.flush) begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end else begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = IDLE;
            end
        end
    end

    // Stall state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shadow pipeline: a bubble loads an all-zero ID/EX entry, downstream stages always advance
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_rs_q  <= '0;
            idex_rt_q  <= '0;
            idex_rd_q  <= '0;
            idex_rw_q  <= 1'b0;
            idex_mr_q  <= 1'b0;
            exmem_rd_q <= '0;
            exmem_rw_q <= 1'b0;
            memwb_rd_q <= '0;
            memwb_rw_q <= 1'b0;
        end else begin
            idex_rs_q  <= bubble ? '0 : hf.id_rs;
            idex_rt_q  <= bubble ? '0 : hf.id_rt;
            idex_rd_q  <= bubble ? '0 : hf.id_rd;
            idex_rw_q  <= !bubble && hf.id_valid && hf.id_regwrite;
            idex_mr_q  <= !bubble && hf.id_valid && hf.id_memread;
            exmem_rd_q <= idex_rd_q;
            exmem_rw_q <= idex_rw_q;
            memwb_rd_q <= exmem_rd_q;
            memwb_rw_q <= exmem_rw_q;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) stall_cycles_q <= '0;
        else if (stall && !(&stall_cycles_q)) stall_cycles_q <= stall_cycles_q + 1'b1;
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: four DUT variants share one stimulus; a deadline-based model checks every cycle
module tb_hazard_forward_unit;
    localparam int N = 4;

    typedef struct packed {
        logic [4:0] rs, rt, rd;
        logic       rw, mr;
    } ent_t;

    typedef struct packed {
        logic [1:0]  fa, fb;
        logic        ia, ib, st, bu;
        logic [15:0] sc;
    } outs_t;

    logic clk, reset;
    logic v, ut, rw, mr, fl;
    logic [4:0] rs, rt, rd;
    outs_t o [N];

    ent_t ex [N], mm [N], wb [N];
    int   until_c [N];
    int   sc [N];
    int   cyc, n_chk, n_pass;
    bit   live;

    hazard_forward_unit_if #(.REG_W(5), .CNT_W(16)) if0 ();
    hazard_forward_unit_if #(.REG_W(5), .CNT_W(16)) if1 ();
    hazard_forward_unit_if #(.REG_W(5), .CNT_W(16)) if2 ();
    hazard_forward_unit_if #(.REG_W(5), .CNT_W(4))  if3 ();

    hazard_forward_unit #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .hf(if0));
    hazard_forward_unit #(.REG_W(5), .LOAD_LAT(2), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .hf(if1));
    hazard_forward_unit #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) u2 (.clk(clk), .reset(reset), .hf(if2));
    hazard_forward_unit #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4))  u3 (.clk(clk), .reset(reset), .hf(if3));

    assign if0.id_valid = v; assign if0.id_rs = rs; assign if0.id_rt = rt; assign if0.id_uses_rt = ut;
    assign if0.id_rd = rd; assign if0.id_regwrite = rw; assign if0.id_memread = mr; assign if0.flush = fl;
    assign if1.id_valid = v; assign if1.id_rs = rs; assign if1.id_rt = rt; assign if1.id_uses_rt = ut;
    assign if1.id_rd = rd; assign if1.id_regwrite = rw; assign if1.id_memread = mr; assign if1.flush = fl;
    assign if2.id_valid = v; assign if2.id_rs = rs; assign if2.id_rt = rt; assign if2.id_uses_rt = ut;
    assign if2.id_rd = rd; assign if2.id_regwrite = rw; assign if2.id_memread = mr; assign if2.flush = fl;
    assign if3.id_valid = v; assign if3.id_rs = rs; assign if3.id_rt = rt; assign if3.id_uses_rt = ut;
    assign if3.id_rd = rd; assign if3.id_regwrite = rw; assign if3.id_memread = mr; assign if3.flush = fl;

    assign o[0] = {if0.fwd_a, if0.fwd_b, if0.fwd_id_a, if0.fwd_id_b, if0.stall, if0.bubble, 16'(if0.stall_cycles)};
    assign o[1] = {if1.fwd_a, if1.fwd_b, if1.fwd_id_a, if1.fwd_id_b, if1.stall, if1.bubble, 16'(if1.stall_cycles)};
    assign o[2] = {if2.fwd_a, if2.fwd_b, if2.fwd_id_a, if2.fwd_id_b, if2.stall, if2.bubble, 16'(if2.stall_cycles)};
    assign o[3] = {if3.fwd_a, if3.fwd_b, if3.fwd_id_a, if3.fwd_id_b, if3.stall, if3.bubble, 16'(if3.stall_cycles)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(int k);
        return k == 1 ? 2 : k == 2 ? 3 : 1;
    endfunction

    function automatic int cw(int k);
        return k == 3 ? 4 : 16;
    endfunction

    function automatic logic [1:0] sel(ent_t m, ent_t w, logic [4:0] src);
        if (m.rw && m.rd != 0 && m.rd == src) return 2'b10;
        if (w.rw && w.rd != 0 && w.rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic hazard(int k);
        return v && !fl && ex[k].mr && ex[k].rw && ex[k].rd != 0 &&
               (ex[k].rd == rs || (ut && ex[k].rd == rt));
    endfunction

    // a hazard opened at cycle c keeps the pipe held until cycle c+LOAD_LAT unless flushed
    function automatic logic m_stall(int k);
        return (cyc < until_c[k]) ? !fl : hazard(k);
    endfunction

    function automatic outs_t model_out(int k);
        outs_t e;
        e.fa = sel(mm[k], wb[k], ex[k].rs);
        e.fb = sel(mm[k], wb[k], ex[k].rt);
        e.ia = v && wb[k].rw && wb[k].rd != 0 && wb[k].rd == rs;
        e.ib = v && ut && wb[k].rw && wb[k].rd != 0 && wb[k].rd == rt;
        e.st = m_stall(k);
        e.bu = e.st || fl;
        e.sc = 16'(sc[k]);
        return e;
    endfunction

    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                ex[k] = '0; mm[k] = '0; wb[k] = '0; until_c[k] = 0; sc[k] = 0;
            end else begin
                logic st;
                st = m_stall(k);
                if (cyc < until_c[k]) begin
                    if (fl) until_c[k] = 0;
                end else if (st) until_c[k] = cyc + lat(k);
                if (st && sc[k] < (1 << cw(k)) - 1) sc[k]++;
                wb[k] = mm[k];
                mm[k] = ex[k];
                ex[k] = (st || fl) ? '0 : {rs, rt, rd, v && rw, v && mr};
            end
        end
        cyc++;
        live = 1'b1;
    endtask

    task automatic step(input logic vv, input logic [4:0] a, b, input logic u,
                        input logic [4:0] d, input logic w, m, f);
        @(posedge clk);
        model_step();
        #1;
        v = vv; rs = a; rt = b; ut = u; rd = d; rw = w; mr = m; fl = f;
        @(negedge clk);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lw4();
        step(1, 1, 0, 0, 4, 1, 1, 0);
    endtask

    task automatic add4(input logic f);
        step(1, 4, 5, 1, 6, 1, 0, f);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        nop();
        reset = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, exp);
    endtask

    // every cycle, every variant against the model
    initial forever begin
        @(negedge clk);
        if (live) for (int k = 0; k < N; k++) begin
            outs_t e;
            e = model_out(k);
            n_chk++;
            if (o[k] === e) n_pass++;
            else $display("FAIL model u%0d @%0t: got fa=%b fb=%b ia=%b ib=%b st=%b bu=%b sc=%0d want fa=%b fb=%b ia=%b ib=%b st=%b bu=%b sc=%0d",
                          k, $time, o[k].fa, o[k].fb, o[k].ia, o[k].ib, o[k].st, o[k].bu, o[k].sc,
                          e.fa, e.fb, e.ia, e.ib, e.st, e.bu, e.sc);
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; live = 1'b0;
        reset = 1'b1;
        {v, rs, rt, ut, rd, rw, mr, fl} = '0;
        repeat (2) step(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                        1'($urandom), 1'($urandom), 1'b0);
        for (int k = 0; k < N; k++) chk($sformatf("reset_outs_u%0d", k), 32'(o[k]), 0);
        reset = 1'b0;
        {v, rs, rt, ut, rd, rw, mr, fl} = '0;
        repeat (10) nop();
        for (int k = 0; k < N; k++) chk($sformatf("nop_sc_u%0d", k), 32'(o[k].sc), 0);

        // two writers of r3, reader in EX sees the younger one
        step(1, 1, 2, 1, 3, 1, 0, 0);
        step(1, 1, 2, 1, 3, 1, 0, 0);
        step(1, 3, 5, 1, 6, 1, 0, 0);
        nop();
        chk("exmem_prio_fa", 32'(o[0].fa), 2);
        chk("unrelated_fb", 32'(o[0].fb), 0);
        step(1, 1, 2, 1, 3, 1, 0, 0);
        step(1, 1, 2, 1, 7, 1, 0, 0);
        step(1, 3, 5, 1, 6, 1, 0, 0);
        nop();
        chk("memwb_fa", 32'(o[0].fa), 1);

        // WB-to-ID bypass, rt only when the instruction reads it
        step(1, 1, 2, 1, 3, 1, 0, 0);
        step(1, 1, 2, 1, 7, 1, 0, 0);
        step(1, 1, 2, 1, 8, 1, 0, 0);
        step(1, 3, 3, 0, 9, 1, 0, 0);
        chk("id_byp_a", 32'(o[0].ia), 1);
        chk("id_byp_b_unused_rt", 32'(o[0].ib), 0);
        step(1, 1, 2, 1, 3, 1, 0, 0);
        step(1, 1, 2, 1, 7, 1, 0, 0);
        step(1, 1, 2, 1, 8, 1, 0, 0);
        step(1, 1, 3, 1, 9, 1, 0, 0);
        chk("id_byp_b", 32'(o[0].ib), 1);
        chk("id_byp_a_other", 32'(o[0].ia), 0);

        // register 0 never forwards or stalls
        step(1, 1, 2, 1, 0, 1, 0, 0);
        step(1, 1, 2, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 9, 1, 0, 0);
        for (int k = 0; k < N; k++) chk($sformatf("r0_stall_u%0d", k), 32'(o[k].st), 0);
        nop();
        chk("r0_fa", 32'(o[0].fa), 0);
        chk("r0_fb", 32'(o[0].fb), 0);

        // load-use, LOAD_LAT=1
        do_reset();
        lw4();
        add4(0);
        chk("l1_stall", 32'(o[0].st), 1);
        chk("l1_bubble", 32'(o[0].bu), 1);
        add4(0);
        chk("l1_release", 32'(o[0].st), 0);
        nop();
        chk("l1_fa", 32'(o[0].fa), 1);
        chk("l1_sc", 32'(o[0].sc), 1);

        // load-use, LOAD_LAT=2
        do_reset();
        lw4();
        add4(0);
        chk("l2_stall1", 32'(o[1].st), 1);
        add4(0);
        chk("l2_stall2", 32'(o[1].st), 1);
        chk("l2_bubble2", 32'(o[1].bu), 1);
        add4(0);
        chk("l2_release", 32'(o[1].st), 0);
        chk("l2_id_byp", 32'(o[1].ia), 1);
        nop();
        chk("l2_fa", 32'(o[1].fa), 0);
        chk("l2_sc", 32'(o[1].sc), 2);

        // detect and flush together: flush wins
        do_reset();
        lw4();
        add4(1);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("detflush_stall_u%0d", k), 32'(o[k].st), 0);
            chk($sformatf("detflush_bubble_u%0d", k), 32'(o[k].bu), 1);
        end

        // flush in the 2nd stall cycle, LOAD_LAT=3
        do_reset();
        lw4();
        add4(0);
        chk("l3_stall1", 32'(o[2].st), 1);
        add4(1);
        chk("l3_flush_stall", 32'(o[2].st), 0);
        chk("l3_flush_bubble", 32'(o[2].bu), 1);
        add4(0);
        chk("l3_idle_after_flush", 32'(o[2].st), 0);
        chk("l3_sc", 32'(o[2].sc), 1);

        // counter saturation: a self-dependent load every other cycle stalls 20 times
        do_reset();
        repeat (42) step(1, 4, 0, 0, 4, 1, 1, 0);
        chk("sat_sc_w4", 32'(o[3].sc), 15);
        chk("sat_sc_w16", 32'(o[0].sc), 20);
        repeat (4) nop();
        chk("sat_hold_w4", 32'(o[3].sc), 15);

        // reset mid-stall aborts it
        lw4();
        add4(0);
        chk("mid_stall", 32'(o[2].st), 1);
        do_reset();
        chk("reset_abort_stall", 32'(o[2].st), 0);
        chk("reset_abort_sc", 32'(o[2].sc), 0);

        // mixed traffic over a few registers, checked only by the model
        repeat (80) step(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                         5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
